// File: rtl/led_bank_arbiter.sv
// Purpose: round-robin arbiter sharing one 4-LED bank between three requesters, with a tick prescaler.
// Latency: gnt one clock after a request or release is seen; LEDs follow the owner's pattern one clock later.
// Backpressure: req is level-held until gnt; after each release a GAP lasts until the next tick. Optional LED_ARB_TIMEOUT_EN.
module led_bank_arbiter #(
    parameter int unsigned TICK_DIV     = 12000,
    parameter int unsigned HOLD_MAX     = 250,
    parameter logic [3:0]  IDLE_PATTERN = 4'b0101
) (
    input  logic       CLK_12_MHZ,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] rel,
    input  logic [3:0] pat0,
    input  logic [3:0] pat1,
    input  logic [3:0] pat2,
    output logic [2:0] gnt,
    output logic       tick,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

    // Reject parameter values outside the supported ranges at elaboration.
    if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick_div
        $error("TICK_DIV out of range 2..65535");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX out of range 1..255");
    end

    logic [1:0]  rst_sync_q;
    logic        arst_n;
    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;
    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  led_q, led_d;
    logic [1:0]  win;
    logic        own_req, own_rel;
    logic [3:0]  own_pat;

    // Reset asserts immediately but deasserts only after two clocks.
    always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign arst_n = rst_sync_q[1];

    // Prescaler: count 0..TICK_DIV-1, pulse tick the clock after the last count.
    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = (cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
    end

    // Round-robin search starting just after the last owner.
    always_comb begin
        win = 2'd0;
        case (last_q)
            2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Current owner's request, release strobe and pattern.
    always_comb begin
        own_req = req[2];
        own_rel = rel[2];
        own_pat = pat2;
        case (last_q)
            2'd0:    begin own_req = req[0]; own_rel = rel[0]; own_pat = pat0; end
            2'd1:    begin own_req = req[1]; own_rel = rel[1]; own_pat = pat1; end
            default: begin own_req = req[2]; own_rel = rel[2]; own_pat = pat2; end
        endcase
    end

`ifdef LED_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic [7:0] hold_q, hold_d, hold_inc;
    logic       timeout_q, timeout_d;
    logic       hold_hit;

    // Ticks owned so far, saturating; the limit is judged on the incremented value
    // so the grant drops on the HOLD_MAX-th tick itself.
    always_comb begin
        hold_inc = (tick_q && hold_q != 8'hFF) ? hold_q + 8'd1 : hold_q;
        hold_hit = (hold_inc >= HOLD_LIM);
        hold_d   = hold_q;
        if (state_q == IDLE)       hold_d = 8'd0;
        else if (state_q == GRANT) hold_d = hold_inc;
    end
`endif

    // Next-state logic: arbitrate in IDLE, hold in GRANT, wait for a tick in GAP.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
`ifdef LED_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 3'b001 << win;
                    last_d  = win;
                end
            end
            GRANT: begin
                // A release outranks a simultaneous timeout.
                if (own_rel || !own_req) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                end
`ifdef LED_ARB_TIMEOUT_EN
                else if (hold_hit) begin
                    state_d   = GAP;
                    gnt_d     = 3'b000;
                    timeout_d = 1'b1;
                end
`endif
            end
            GAP: begin
                if (tick_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
        led_d = (state_q == GRANT) ? own_pat : IDLE_PATTERN;
    end

    // State, grant and LED registers; last owner resets to 2 so requester 0 wins first.
    always_ff @(posedge CLK_12_MHZ or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q   <= 16'd0;
            tick_q  <= 1'b0;
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            last_q  <= 2'd2;
            led_q   <= IDLE_PATTERN;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            led_q   <= led_d;
        end
    end

`ifdef LED_ARB_TIMEOUT_EN
    // Hold counter and timeout pulse register.
    always_ff @(posedge CLK_12_MHZ or negedge arst_n) begin
        if (!arst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign tick = tick_q;
    assign busy = (state_q != IDLE);
    assign {led4, led3, led2, led1} = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with TICK_DIV=4, HOLD_MAX=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived constants per step.
module tb_led_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req, rel;
    logic [3:0] pat0, pat1, pat2;
    logic [2:0] gnt;
    logic       tick, led1, led2, led3, led4, busy, timeout;
    logic [3:0] leds;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;
    assign leds = {led4, led3, led2, led1};

    led_bank_arbiter #(.TICK_DIV(4), .HOLD_MAX(3), .IDLE_PATTERN(4'b0101)) dut (
        .CLK_12_MHZ(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .pat0(pat0), .pat1(pat1), .pat2(pat2),
        .gnt(gnt), .tick(tick), .led1(led1), .led2(led2), .led3(led3), .led4(led4),
        .busy(busy), .timeout(timeout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stay on the current falling edge if tick is already high, else advance until it is.
    task automatic wait_tick(input string tag);
        int k = 0;
        while (tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, {7'd0, (k < 20)}, 8'd1);
    endtask

    // Pulse rel for one clock; the caller observes the result on the next falling edge.
    task automatic pulse_rel(input logic [2:0] r);
        rel = r;
        @(negedge clk);
        rel = 3'b000;
    endtask

    initial begin
        int n;
        logic tout_seen;
        rst_n = 1'b0; req = 3'b000; rel = 3'b000;
        pat0 = 4'b1100; pat1 = 4'b1010; pat2 = 4'b0011;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", {5'd0, gnt}, 8'h0);
        check("rst_tick", {7'd0, tick}, 8'h0);
        check("rst_busy", {7'd0, busy}, 8'h0);
        check("rst_timeout", {7'd0, timeout}, 8'h0);
        check("rst_leds", {4'd0, leds}, 8'h5);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_noreq_gnt", {5'd0, gnt}, 8'h0);
        check("idle_noreq_busy", {7'd0, busy}, 8'h0);

        // Round-robin sequence with all three requesting
        req = 3'b111;
        @(negedge clk);
        check("rr1_gnt", {5'd0, gnt}, 8'h1);
        check("rr1_busy", {7'd0, busy}, 8'h1);
        check("rr1_leds_lat", {4'd0, leds}, 8'h5);
        @(negedge clk);
        check("rr1_leds", {4'd0, leds}, 8'hC);
        pulse_rel(3'b001);
        check("rr1_rel_gnt", {5'd0, gnt}, 8'h0);
        check("rr1_gap_busy", {7'd0, busy}, 8'h1);
        wait_tick("rr1_gap_tick");
        check("rr1_gap_busy_at_tick", {7'd0, busy}, 8'h1);
        @(negedge clk);
        check("rr1_idle_busy", {7'd0, busy}, 8'h0);
        @(negedge clk);
        check("rr2_gnt", {5'd0, gnt}, 8'h2);
        check("rr2_leds_lat", {4'd0, leds}, 8'h5);
        @(negedge clk);
        check("rr2_leds", {4'd0, leds}, 8'hA);
        pat1 = 4'b0110;
        @(negedge clk);
        check("rr2_leds_track", {4'd0, leds}, 8'h6);
        pulse_rel(3'b010);
        check("rr2_rel_gnt", {5'd0, gnt}, 8'h0);
        @(negedge clk);
        check("rr2_gap_leds", {4'd0, leds}, 8'h5);
        wait_tick("rr2_gap_tick");
        @(negedge clk);
        @(negedge clk);
        check("rr3_gnt", {5'd0, gnt}, 8'h4);
        req = 3'b011;
        @(negedge clk);
        check("rr3_reqdrop_gnt", {5'd0, gnt}, 8'h0);
        check("rr3_gap_busy", {7'd0, busy}, 8'h1);
        req = 3'b111;
        wait_tick("rr3_gap_tick");
        @(negedge clk);
        @(negedge clk);
        check("rr4_gnt", {5'd0, gnt}, 8'h1);

        // Non-owner rel and req changes are ignored
        req = 3'b101;
        pulse_rel(3'b100);
        check("nonowner_rel_gnt", {5'd0, gnt}, 8'h1);
        pulse_rel(3'b001);
        check("owner_rel_gnt", {5'd0, gnt}, 8'h0);
        check("owner_rel_busy", {7'd0, busy}, 8'h1);
        wait_tick("owner_rel_tick");
        check("owner_rel_busy_at_tick", {7'd0, busy}, 8'h1);
        @(negedge clk);
        check("owner_rel_idle", {7'd0, busy}, 8'h0);
        @(negedge clk);
        check("rr_skip_gnt", {5'd0, gnt}, 8'h4);

        // Release coincident with tick: full GAP of 4 clocks
        wait_tick("coinc_tick");
        check("coinc_owner", {5'd0, gnt}, 8'h4);
        pulse_rel(3'b100);
        check("coinc_rel_gnt", {5'd0, gnt}, 8'h0);
        n = 0;
        while (busy === 1'b1 && n < 12) begin
            n++;
            @(negedge clk);
        end
        check("coinc_gap_clocks", 8'(n), 8'd4);
        @(negedge clk);
        check("after_coinc_gnt", {5'd0, gnt}, 8'h1);

`ifdef LED_ARB_TIMEOUT_EN
        // Owner never releases: forced revoke, then next requester
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_seen", {7'd0, (n < 40)}, 8'h1);
        check("to_gnt", {5'd0, gnt}, 8'h0);
        @(negedge clk);
        check("to_pulse_once", {7'd0, timeout}, 8'h0);
        wait_tick("to_gap_tick");
        @(negedge clk);
        @(negedge clk);
        check("to_next_gnt", {5'd0, gnt}, 8'h4);
`else
        // Without the timeout option ownership is unbounded
        tout_seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            tout_seen = tout_seen | timeout;
        end
        check("notimeout_pulse", {7'd0, tout_seen}, 8'h0);
        check("notimeout_gnt", {5'd0, gnt}, 8'h1);
`endif

        // Reset asserted between edges mid-GRANT
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", {5'd0, gnt}, 8'h0);
        check("midrst_leds", {4'd0, leds}, 8'h5);
        check("midrst_busy", {7'd0, busy}, 8'h0);
        check("midrst_timeout", {7'd0, timeout}, 8'h0);
        req = 3'b110;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (gnt === 3'b000 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("postrst_first_gnt", {5'd0, gnt}, 8'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
